// File: rtl/cmd_frame_ctrl_if.sv
// cmd_frame_ctrl_if: bus between the command-frame controller and its peers
//   rx_data/rx_valid          : received byte stream from the UART RX
//   rf_*                      : register-file write/read requests and read return
//   alu_*                     : ALU start, function select and result return
//   fifo_*                    : TX FIFO push with full-flag backpressure
//   frame_err, ctrl_busy      : status
// modport master is the controller side, modport slave the environment side.
interface cmd_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_valid;
  logic                    alu_en;
  logic [FUNC_WIDTH-1:0]   alu_func;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_valid;
  logic                    fifo_wr_en;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  logic                    fifo_full;
  logic                    frame_err;
  logic                    ctrl_busy;
  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, fifo_full,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_func, fifo_wr_en, fifo_wr_data,
           frame_err, ctrl_busy
  );
  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, fifo_full,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_func, fifo_wr_en, fifo_wr_data,
           frame_err, ctrl_busy
  );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: decodes UART command frames into register-file/ALU requests and TX FIFO responses
//   CLK : system clock
//   RST : asynchronous active-low reset
//   bus : cmd_frame_ctrl_if.master (RX bytes in, RF/ALU requests out, FIFO pushes out, status out)
module cmd_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUNC_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] CMD_WR       = 'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD       = 'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP   = 'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP  = 'hDD,
  parameter logic [DATA_WIDTH-1:0] CMD_BURST_WR = 'hEE
) (
  input logic CLK,
  input logic RST,
  cmd_frame_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND,
    ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, ALU_LO, ALU_HI,
    BW_ADDR, BW_CNT, BW_DATA
  } state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d, alu_en_q, alu_en_d;
  logic                    frame_err_q, frame_err_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [FUNC_WIDTH-1:0]   alu_func_q, alu_func_d;
  logic send, wait_st, rx, rsp, counting, expire;
  logic [DATA_WIDTH-1:0] b;
  assign b        = bus.rx_data;
  assign send     = state_q inside {RD_SEND, ALU_LO, ALU_HI};
  assign wait_st  = state_q inside {RD_WAIT, ALU_WAIT};
  // bytes arriving while waiting on a response or sending one are dropped
  assign rx       = bus.rx_valid && !send && !wait_st;
  assign rsp      = (state_q == RD_WAIT && bus.rf_rd_valid) || (state_q == ALU_WAIT && bus.alu_out_valid);
  assign counting = state_q != IDLE && !send;
  // a response or byte in the terminal cycle counts as progress, so it beats the timeout
  assign expire   = counting && !rx && !rsp && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_func_d   = alu_func_q;
    frame_err_d  = bus.rx_valid && (send || wait_st);
    tmo_d        = (counting && !rx && !rsp) ? tmo_q + 1'b1 : '0;
    if (expire) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (rx) begin
          state_d = b == CMD_WR       ? WR_ADDR  :
                    b == CMD_RD       ? RD_ADDR  :
                    b == CMD_ALU_OP   ? ALU_A    :
                    b == CMD_ALU_NOP  ? ALU_FUNC :
                    b == CMD_BURST_WR ? BW_ADDR  : IDLE;
          frame_err_d = !(b inside {CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP, CMD_BURST_WR});
        end
        WR_ADDR: if (rx) begin
          addr_d  = b[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: if (rx) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = b;
          state_d      = IDLE;
        end
        RD_ADDR: if (rx) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = b[ADDR_WIDTH-1:0];
          state_d    = RD_WAIT;
        end
        RD_WAIT: if (rsp) begin
          res_d   = {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
          state_d = RD_SEND;
        end
        RD_SEND: state_d = bus.fifo_full ? RD_SEND : IDLE;
        ALU_A: if (rx) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = '0;
          rf_wr_data_d = b;
          state_d      = ALU_B;
        end
        ALU_B: if (rx) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = b;
          state_d      = ALU_FUNC;
        end
        ALU_FUNC: if (rx) begin
          alu_en_d   = 1'b1;
          alu_func_d = b[FUNC_WIDTH-1:0];
          state_d    = ALU_WAIT;
        end
        ALU_WAIT: if (rsp) begin
          res_d   = bus.alu_out;
          state_d = ALU_LO;
        end
        ALU_LO: state_d = bus.fifo_full ? ALU_LO : ALU_HI;
        ALU_HI: state_d = bus.fifo_full ? ALU_HI : IDLE;
        BW_ADDR: if (rx) begin
          addr_d  = b[ADDR_WIDTH-1:0];
          state_d = BW_CNT;
        end
        BW_CNT: if (rx) begin
          cnt_d       = b;
          state_d     = b == '0 ? IDLE : BW_DATA;
          frame_err_d = b == '0;
        end
        BW_DATA: if (rx) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = b;
          addr_d       = addr_q + 1'b1;
          cnt_d        = cnt_q - 1'b1;
          state_d      = cnt_q == DATA_WIDTH'(1) ? IDLE : BW_DATA;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      tmo_q        <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_func_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      tmo_q        <= tmo_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
      frame_err_q  <= frame_err_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_func_q   <= alu_func_d;
    end
  end
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_rd_en     = rf_rd_en_q;
  assign bus.alu_en       = alu_en_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.alu_func     = alu_func_q;
  // the push is qualified by the live full flag so a byte is never offered to a full FIFO
  assign bus.fifo_wr_en   = send && !bus.fifo_full;
  assign bus.fifo_wr_data = state_q == ALU_HI ? res_q[2*DATA_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];
  assign bus.ctrl_busy    = state_q != IDLE;
endmodule

// File: doc/cmd_frame_ctrl.md
Name: cmd_frame_ctrl

Overview:
- Parametrised successor to the system-controller path that sits between the UART RX parallel output and the register file, ALU and TX FIFO.
- Decodes multi-byte command frames from rx_data/rx_valid, drives register-file and ALU requests, and pushes response bytes into the TX FIFO with full-flag backpressure.
- Adds over the previous generation: generic widths, burst-write command, inter-byte frame timeout, and error reporting.
- Single clock domain; the FIFO handles any TX clock crossing.

Parameters:
- DATA_WIDTH, 8: width of the RX byte, register data and FIFO data.
- ADDR_WIDTH, 4: register-file address width. The address is taken from the low ADDR_WIDTH bits of the address byte.
- FUNC_WIDTH, 4: ALU function width. The function is taken from the low FUNC_WIDTH bits of the function byte.
- TIMEOUT_CYCLES, 1024: maximum number of idle CLK cycles allowed between frame bytes, or while waiting on a response, before the frame is aborted.
- CMD_WR, 8'hAA: register write command, frame = CMD, ADDR, DATA.
- CMD_RD, 8'hBB: register read command, frame = CMD, ADDR.
- CMD_ALU_OP, 8'hCC: ALU with operands, frame = CMD, A, B, FUNC.
- CMD_ALU_NOP, 8'hDD: ALU on stored operands, frame = CMD, FUNC.
- CMD_BURST_WR, 8'hEE: burst register write, frame = CMD, ADDR, N, D0..D(N-1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- rx_data  in  DATA_WIDTH  received byte.
- rx_valid  in  1  one-cycle strobe per received byte.
- rf_wr_en  out  1  register-file write strobe.
- rf_rd_en  out  1  register-file read strobe.
- rf_addr  out  ADDR_WIDTH  register-file address.
- rf_wr_data  out  DATA_WIDTH  register-file write data.
- rf_rd_data  in  DATA_WIDTH  register-file read data.
- rf_rd_valid  in  1  read data valid.
- alu_en  out  1  ALU start strobe.
- alu_func  out  FUNC_WIDTH  ALU function.
- alu_out  in  2*DATA_WIDTH  ALU result.
- alu_out_valid  in  1  ALU result valid.
- fifo_wr_en  out  1  TX FIFO push.
- fifo_wr_data  out  DATA_WIDTH  TX FIFO data.
- fifo_full  in  1  TX FIFO full.
- frame_err  out  1  one-cycle error pulse.
- ctrl_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:

Reset:
- RST low sets every output to 0 and the FSM to IDLE, clears the timeout counter and burst counter, and aborts any frame in progress.
- A partially received frame produces no register write, ALU strobe or FIFO push after reset.

FSM states:
- IDLE
- WR_ADDR, WR_DATA
- RD_ADDR, RD_WAIT, RD_SEND
- ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, ALU_LO, ALU_HI
- BW_ADDR, BW_CNT, BW_DATA

IDLE command decode (on rx_valid):
- CMD_WR -> WR_ADDR; CMD_RD -> RD_ADDR; CMD_ALU_OP -> ALU_A; CMD_ALU_NOP -> ALU_FUNC; CMD_BURST_WR -> BW_ADDR.
- Any other byte: stay in IDLE and pulse frame_err.

Latency:
- All strobes (rf_wr_en, rf_rd_en, alu_en) are one-cycle pulses asserted in the cycle after the rx_valid that completes them.
- rf_addr, rf_wr_data and alu_func are valid alongside their strobe.

Register write:
- WR_DATA byte: rf_wr_en with the captured address, then -> IDLE.

Register read:
- RD_ADDR byte: rf_rd_en, then -> RD_WAIT.
- On rf_rd_valid, capture rf_rd_data, then -> RD_SEND.

ALU with operands:
- ALU_A byte: rf_wr_en to address 0 with A.
- ALU_B byte: rf_wr_en to address 1 with B.
- ALU_FUNC byte: alu_en, then -> ALU_WAIT.
- On alu_out_valid, capture alu_out.
- ALU_LO pushes the low byte, then ALU_HI pushes the high byte, then -> IDLE.

Burst write:
- BW_ADDR captures the start address.
- BW_CNT captures N as unsigned. N=0 pulses frame_err and goes to IDLE with no writes.
- Each BW_DATA byte: rf_wr_en at the current address, then address+1 modulo 2^ADDR_WIDTH (wraps from max to 0).
- After the Nth data byte -> IDLE.

FIFO push:
- In a send state, fifo_wr_en is asserted only when fifo_full=0, for exactly one cycle per byte.
- While fifo_full=1, hold the state and data indefinitely. The timeout does not run.

Timeout:
- The counter runs in every non-IDLE state except send states and resets on each accepted rx_valid.
- Reaching TIMEOUT_CYCLES pulses frame_err and returns the FSM to IDLE, with no further strobes for that frame.

Overrun:
- rx_valid during RD_WAIT, ALU_WAIT or any send state drops the byte and pulses frame_err.
- The current operation still completes.

Simultaneous events:
- rf_rd_valid or alu_out_valid arriving in the same cycle as the timeout terminal count: the valid wins, and there is no error.

Test Plan:
- Write: AA,05,3C -> one rf_wr_en pulse with addr=5, data=3C; no FIFO push; ctrl_busy returns to 0.
- Read: BB,05 with rf_rd_data=3C valid 2 cycles later -> rf_rd_en at addr 5, then one FIFO push of 3C.
- ALU with operands: CC,8A,AA,04 with alu_out=0x1234 -> rf writes addr0=8A and addr1=AA, alu_en with func=4, then FIFO pushes 34 then 12.
- ALU without operands under backpressure: DD,00 with alu_out=0x00FF and fifo_full held high 10 cycles -> no push while full; after release, pushes FF then 00, each exactly once.
- Burst with wrap: EE,0E,03,11,22,33 -> writes addr E=11, F=22, 0=33; then EE,02,00 -> frame_err and no writes.
- Errors: byte 5A in IDLE -> frame_err; AA,05 then silence for TIMEOUT_CYCLES -> frame_err, IDLE, no write; RST low mid-frame, then AA,01,77 -> only the 01/77 write occurs.
